// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter: op encodings, flag bit
// positions and the response-slot state type.
package alu_arb_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam int NUM_REQ = 2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} rsp_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational. The pointer moves
// to the loser of the last accept.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  input  logic       i_accept_id,
  output logic [1:0] o_grant,
  output logic       o_rr_ptr
);

  logic rr_ptr_q;

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11)
      o_grant = rr_ptr_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)         rr_ptr_q <= 1'b0;
    else if (i_accept) rr_ptr_q <= ~i_accept_id;
  end

  assign o_rr_ptr = rr_ptr_q;

endmodule

// File: rtl/alu_nzcv.sv
// N-bit ALU (add/sub/and/or) with NZCV flags. The result wraps modulo 2^N.
// C and V are produced only by add/sub.
module alu_nzcv
  import alu_arb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [1:0]   i_ctrl,
  output logic [N-1:0] o_result,
  output logic [3:0]   o_nzcv
);

  logic         is_sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;

  // Subtraction is computed as a + ~b + 1, so C means "no borrow".
  assign is_sub = (i_ctrl == ALU_SUB);
  assign b_eff  = is_sub ? ~i_b : i_b;
  assign sum    = {1'b0, i_a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};

  always_comb begin
    o_result = '0;
    o_nzcv   = '0;
    case (i_ctrl)
      ALU_ADD, ALU_SUB: begin
        o_result       = sum[N-1:0];
        o_nzcv[FLAG_C] = sum[N];
        o_nzcv[FLAG_V] = (i_a[N-1] == b_eff[N-1]) && (sum[N-1] != i_a[N-1]);
      end
      ALU_AND: o_result = i_a & i_b;
      default: o_result = i_a | i_b;
    endcase
    o_nzcv[FLAG_N] = o_result[N-1];
    o_nzcv[FLAG_Z] = (o_result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu_nzcv between two valid/ready requesters. Each accepted op
// lands in a single response register, and each requester has its own flags.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [1:0]   i_valid,
  output logic [1:0]   o_ready,
  input  logic [N-1:0] i_a0,
  input  logic [N-1:0] i_b0,
  input  logic [N-1:0] i_a1,
  input  logic [N-1:0] i_b1,
  input  logic [1:0]   i_ctrl0,
  input  logic [1:0]   i_ctrl1,
  input  logic [1:0]   i_setflags,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic         o_rsp_id,
  output logic [N-1:0] o_rsp_result,
  output logic [3:0]   o_rsp_nzcv,
  output logic [3:0]   o_flags0,
  output logic [3:0]   o_flags1
);

  rsp_state_t state_q, state_d;

  logic [1:0]         grant;
  logic               rr_ptr;
  logic               slot_free;
  logic [1:0]         accept_vec;
  logic               accept;
  logic               gid;
  logic [N-1:0]       alu_a, alu_b, alu_result;
  logic [1:0]         alu_ctrl;
  logic [3:0]         alu_nzcv_w;
  logic [NUM_REQ-1:0][3:0] flags_q;

  rr_arb2 u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_accept    (accept),
    .i_accept_id (gid),
    .o_grant     (grant),
    .o_rr_ptr    (rr_ptr)
  );

  // Reset masks ready so nothing is accepted on a reset edge.
  assign slot_free  = (state_q == EMPTY) | i_rsp_ready;
  assign o_ready    = grant & {2{slot_free & ~i_rst}};
  assign accept_vec = i_valid & o_ready;
  assign accept     = |accept_vec;
  assign gid        = o_ready[1];

  assign alu_a    = gid ? i_a1    : i_a0;
  assign alu_b    = gid ? i_b1    : i_b0;
  assign alu_ctrl = gid ? i_ctrl1 : i_ctrl0;

  alu_nzcv #(.N(N)) u_alu (
    .i_a      (alu_a),
    .i_b      (alu_b),
    .i_ctrl   (alu_ctrl),
    .o_result (alu_result),
    .o_nzcv   (alu_nzcv_w)
  );

  always_comb begin
    state_d = state_q;
    if (accept)           state_d = FULL;
    else if (i_rsp_ready) state_d = EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Data registers only load on accept; a plain drain leaves them as-is.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_id     <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_nzcv   <= '0;
    end else if (accept) begin
      o_rsp_id     <= gid;
      o_rsp_result <= alu_result;
      o_rsp_nzcv   <= alu_nzcv_w;
    end
  end

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_flags
    always_ff @(posedge i_clk) begin
      if (i_rst)                             flags_q[r] <= '0;
      else if (accept_vec[r] & i_setflags[r]) flags_q[r] <= alu_nzcv_w;
    end
  end

  assign o_rsp_valid = (state_q == FULL);
  assign o_flags0    = flags_q[0];
  assign o_flags1    = flags_q[1];

  logic unused_ok;
  assign unused_ok = rr_ptr;

endmodule
